matrix_product_sequencer: RTL and testbench
===========================================

Name: matrix_product_sequencer

Overview:
- Initiator-side controller that drives a column_processor through a full size x size matrix product C = A x B.
- Latches operand matrices A and B from a host and steps through C cells in row-major order.
- For each cell, presents row i of A and column j of B to the processor, waits for its result, collects it into C, and releases it with an acknowledge.
- Returns the completed C to the host under a ready/ack handshake.

Parameters:
size, 4, matrix dimension (rows = cols)
cell_width, 32, bits per element (IEEE-754 single)
width, cell_width*size, bits per row/column vector
timeout_cycles, 1024, max cycles waited for one processor result before abort

Ports:
in_clk  input  1  clock, all logic on rising edge
in_reset  input  1  synchronous, active-high reset
in_ready  input  1  host: operands valid, start product
in_mat_a  input  width*size  A, row-major; a(i,k) at bits [(i*size+k)*cell_width +: cell_width]
in_mat_b  input  width*size  B, row-major, same layout
in_ack  input  1  host accepts result
out_mat_c  output  width*size  C, row-major, same layout
out_ready  output  1  C valid
out_error  output  1  processor timeout occurred during this product
out_row_a  output  width  to processor in_row_a; element k at [k*cell_width +: cell_width]
out_col_b  output  width  to processor in_col_b; element k = b(k,j)
out_proc_ready  output  1  to processor in_ready
in_proc_cell  input  width  from processor out_cell_c; result in low cell_width bits, upper bits ignored
in_proc_ready  input  1  from processor out_ready
out_proc_ack  output  1  to processor out_ack

Behaviour:
- Reset (sync, active-high, overrides everything including mid-operation):
  - All outputs 0, out_mat_c cleared, i=j=0, timeout counter 0, state IDLE.
- States: IDLE, ISSUE, WAIT, RELEASE, DONE.
- IDLE:
  - out_ready=0, out_proc_ready=0, out_proc_ack=0.
  - On in_ready=1: latch in_mat_a/in_mat_b into internal registers, clear out_mat_c and out_error, i=j=0, go to ISSUE.
  - Later changes to in_mat_a/in_mat_b have no effect until the next start.
- ISSUE:
  - Drive out_row_a = row i of latched A and out_col_b = column j of latched B.
  - out_proc_ready=1 for exactly this one cycle; clear timeout counter; go to WAIT.
- WAIT:
  - out_proc_ready=0; out_row_a/out_col_b held stable, because the processor samples them one cycle after seeing ready.
  - Timeout counter increments each cycle.
  - On in_proc_ready=1: write in_proc_cell[cell_width-1:0] to c(i,j), set out_proc_ack=1, go to RELEASE.
  - On counter = timeout_cycles-1 with no result: set out_error=1, leave c(i,j)=0, set out_proc_ack=1, go to RELEASE (the cell is skipped).
- RELEASE:
  - Hold out_proc_ack=1 until in_proc_ready=0 is sampled; then deassert out_proc_ack the following cycle.
  - At that point, advance the index: j+1; on wrap (j=size-1) j=0 and i+1.
  - If (i,j) was (size-1,size-1), go to DONE; else go to ISSUE.
  - In the timeout case in_proc_ready is already 0, so RELEASE lasts one cycle.
  - out_proc_ready is never 1 in RELEASE, so the processor cannot restart spuriously.
- DONE:
  - out_ready=1; out_mat_c and out_error held.
  - On in_ack=1: go to IDLE (out_ready=0 the next cycle).
  - out_mat_c is retained in IDLE until the next start.
  - in_ready is ignored while not in IDLE.
- Simultaneous in_ack and in_ready in DONE: return to IDLE only. A new start needs in_ready sampled in IDLE.
- Ordering: exactly size*size processor transactions per product, row-major, never overlapped.
- No arithmetic is performed here; the block only slices, gathers and places vectors.

Test Plan:
- Basic 2x2 product, size=2, behavioural processor model with 5-cycle latency.
  - Stimulus: A=[[1,2],[3,4]] (3F800000, 40000000, 40400000, 40800000), B=[[5,6],[7,8]] (40A00000, 40C00000, 40E00000, 41000000).
  - First issue must show out_row_a=64'h400000003F800000 and out_col_b=64'h40E0000040A00000.
  - Final out_mat_c cells must be 41980000, 41B00000, 422C0000, 42480000 (19, 22, 43, 50); out_error=0.
- Handshake timing: model holds out_ready 3 extra cycles after ack.
  - out_proc_ack stays high until in_proc_ready falls.
  - The next out_proc_ready pulse is exactly one cycle wide and only after ack drops.
  - Operands stay stable throughout WAIT.
- Timeout: timeout_cycles=16; model never answers cell (0,1).
  - out_error=1 and c(0,1)=0; all other cells correct.
  - Total transactions = 4.
- Reset mid-operation: assert in_reset during WAIT of cell (1,0).
  - Next cycle all outputs 0 and state IDLE.
  - A new start completes correctly.
- Back-to-back products, size=4:
  - Second in_ready is held high through DONE plus in_ack; the second product starts only from IDLE.
  - Result with A = identity (3F800000 on the diagonal) equals B bit-exact.
- Upper-bit masking: model returns garbage in in_proc_cell[width-1:cell_width] → only the low cell_width bits are stored in C.

Source files
------------

// File: rtl/matrix_product_sequencer.sv
// Sequences a size x size matrix product through an external column_processor,
// one C cell per processor transaction in row-major order.
//
//  state       | meaning
//  ------------+------------------------------------------------------------
//  st_idle     | waiting for host in_ready; C and error from last product held
//  st_issue    | one-cycle out_proc_ready pulse with row i of A / column j of B
//  st_wait     | operands held, timeout down-counter running, waiting on result
//  st_release  | out_proc_ack high until processor drops its ready, then advance
//  st_done     | out_ready high until host acknowledges
module matrix_product_sequencer #(
   parameter int size           = 4,
   parameter int cell_width     = 32,
   parameter int width          = cell_width * size,
   parameter int timeout_cycles = 1024
) (
   input  logic                  in_clk,
   input  logic                  in_reset,
   input  logic                  in_ready,
   input  logic [width*size-1:0] in_mat_a,
   input  logic [width*size-1:0] in_mat_b,
   input  logic                  in_ack,
   output logic [width*size-1:0] out_mat_c,
   output logic                  out_ready,
   output logic                  out_error,
   output logic [width-1:0]      out_row_a,
   output logic [width-1:0]      out_col_b,
   output logic                  out_proc_ready,
   input  logic [width-1:0]      in_proc_cell,
   input  logic                  in_proc_ready,
   output logic                  out_proc_ack
);

   localparam int idx_w = (size > 1) ? $clog2(size) : 1;
   localparam int tmr_w = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
   localparam logic [idx_w-1:0] idx_last = idx_w'(size - 1);
   localparam logic [tmr_w-1:0] tmr_load = tmr_w'(timeout_cycles - 1);

   typedef enum logic [2:0] {
      st_idle,
      st_issue,
      st_wait,
      st_release,
      st_done
   } state_t;

   state_t                  state_q, state_d;
   logic [width*size-1:0]   a_q, b_q, c_q;
   logic [idx_w-1:0]        i_q, j_q;
   logic [tmr_w-1:0]        tmr_q;
   logic                    err_q;
   logic                    last_cell;
   logic                    tmr_done;
   logic [width-1:0]        col_sel;

   // The processor only returns a single cell; the rest of its bus is don't-care.
   logic unused_proc_bits;
   assign unused_proc_bits = ^in_proc_cell[width-1:cell_width];

   assign last_cell = (i_q == idx_last) && (j_q == idx_last);
   assign tmr_done  = (tmr_q == '0);

   always_comb begin
      col_sel = '0;
      for (int k = 0; k < size; k++) begin
         col_sel[k*cell_width +: cell_width] =
            b_q[(k*size + int'(j_q))*cell_width +: cell_width];
      end
   end

   assign out_row_a = a_q[int'(i_q)*width +: width];
   assign out_col_b = col_sel;
   assign out_mat_c = c_q;
   assign out_error = err_q;

   always_comb begin
      state_d        = state_q;
      out_ready      = 1'b0;
      out_proc_ready = 1'b0;
      out_proc_ack   = 1'b0;
      case (state_q)
         st_idle: begin
            if (in_ready) state_d = st_issue;
         end
         st_issue: begin
            out_proc_ready = 1'b1;
            state_d        = st_wait;
         end
         st_wait: begin
            if (in_proc_ready || tmr_done) state_d = st_release;
         end
         st_release: begin
            out_proc_ack = 1'b1;
            if (!in_proc_ready) state_d = last_cell ? st_done : st_issue;
         end
         st_done: begin
            out_ready = 1'b1;
            if (in_ack) state_d = st_idle;
         end
         default: state_d = st_idle;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state_q <= st_idle;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         tmr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            st_idle: begin
               if (in_ready) begin
                  a_q   <= in_mat_a;
                  b_q   <= in_mat_b;
                  c_q   <= '0;
                  err_q <= 1'b0;
                  i_q   <= '0;
                  j_q   <= '0;
               end
            end
            st_issue: tmr_q <= tmr_load;
            st_wait: begin
               // A result arriving on the terminal cycle still wins over the timeout.
               if (in_proc_ready) begin
                  c_q[(int'(i_q)*size + int'(j_q))*cell_width +: cell_width] <=
                     in_proc_cell[cell_width-1:0];
               end else if (tmr_done) begin
                  err_q <= 1'b1;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            st_release: begin
               if (!in_proc_ready) begin
                  if (j_q == idx_last) begin
                     j_q <= '0;
                     i_q <= i_q + 1'b1;
                  end else begin
                     j_q <= j_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_product_sequencer.sv
// Directed bench: a 2x2 instance (short timeout) and a 4x4 instance, each driven
// by a behavioural column_processor model that returns table-supplied results.
module tb_matrix_product_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] row_of(input logic [511:0] m, input int sz, input int r);
      logic [127:0] v = '0;
      for (int k = 0; k < sz; k++) v[k*32 +: 32] = m[(r*sz + k)*32 +: 32];
      return v;
   endfunction

   function automatic logic [127:0] col_of(input logic [511:0] m, input int sz, input int c);
      logic [127:0] v = '0;
      for (int k = 0; k < sz; k++) v[k*32 +: 32] = m[(k*sz + c)*32 +: 32];
      return v;
   endfunction

   typedef enum int {m_idle, m_sample, m_busy, m_out, m_hold} mstate_t;

   // ---------------- 2x2 instance ----------------
   logic         d2_in_ready = 1'b0, d2_ack = 1'b0;
   logic [127:0] d2_mat_a = '0, d2_mat_b = '0, d2_mat_c;
   logic         d2_out_ready, d2_out_error, d2_proc_ready, d2_proc_ack;
   logic [63:0]  d2_row_a, d2_col_b;
   logic         p2_ready = 1'b0;
   logic [63:0]  p2_cell = '0;

   matrix_product_sequencer #(.size(2), .cell_width(32), .width(64), .timeout_cycles(16)) dut2 (
      .in_clk(clk), .in_reset(rst), .in_ready(d2_in_ready), .in_mat_a(d2_mat_a),
      .in_mat_b(d2_mat_b), .in_ack(d2_ack), .out_mat_c(d2_mat_c), .out_ready(d2_out_ready),
      .out_error(d2_out_error), .out_row_a(d2_row_a), .out_col_b(d2_col_b),
      .out_proc_ready(d2_proc_ready), .in_proc_cell(p2_cell), .in_proc_ready(p2_ready),
      .out_proc_ack(d2_proc_ack));

   mstate_t      m2_st = m_idle;
   int           txn2 = 0, m2_cnt = 0, m2_hold = 0;
   int           lat2 = 5, hold2 = 0, skip2 = -1;
   bit           garbage2 = 1'b0;
   logic [31:0]  res2 [4];
   logic [511:0] a_exp2 = '0, b_exp2 = '0;
   logic         prev_rdy2 = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m2_st <= m_idle; p2_ready <= 1'b0; p2_cell <= '0; txn2 <= 0;
      end else begin
         case (m2_st)
            m_idle: if (d2_proc_ready) begin txn2 <= txn2 + 1; m2_st <= m_sample; end
            m_sample: begin
               if (((txn2 - 1) % 4) == skip2) m2_st <= m_idle;
               else begin m2_cnt <= lat2; m2_st <= m_busy; end
            end
            m_busy: begin
               if (m2_cnt <= 1) begin
                  p2_ready <= 1'b1;
                  p2_cell  <= {(garbage2 ? 32'hDEADBEEF : 32'h0), res2[(txn2 - 1) % 4]};
                  m2_st    <= m_out;
               end else m2_cnt <= m2_cnt - 1;
            end
            m_out: begin
               if (d2_proc_ack) begin
                  if (hold2 == 0) begin p2_ready <= 1'b0; m2_st <= m_idle; end
                  else begin m2_hold <= hold2; m2_st <= m_hold; end
               end
            end
            m_hold: begin
               if (m2_hold <= 1) begin p2_ready <= 1'b0; m2_st <= m_idle; end
               else m2_hold <= m2_hold - 1;
            end
            default: m2_st <= m_idle;
         endcase
      end
   end

   // Handshake and operand-stability monitor for the 2x2 instance.
   always @(negedge clk) begin
      if (!rst) begin
         if (m2_st != m_idle) begin
            check("row_a_held", d2_row_a, row_of(a_exp2, 2, ((txn2 - 1) % 4) / 2));
            check("col_b_held", d2_col_b, col_of(b_exp2, 2, ((txn2 - 1) % 4) % 2));
         end
         if (m2_st == m_hold) check("ack_held_while_ready", d2_proc_ack, 1);
         if (d2_proc_ready) begin
            check("issue_after_ack_drop", {p2_ready, d2_proc_ack}, 0);
            check("issue_one_cycle", prev_rdy2, 0);
         end
      end
      prev_rdy2 = d2_proc_ready;
   end

   // ---------------- 4x4 instance ----------------
   logic         d4_in_ready = 1'b0, d4_ack = 1'b0;
   logic [511:0] d4_mat_a = '0, d4_mat_b = '0, d4_mat_c;
   logic         d4_out_ready, d4_out_error, d4_proc_ready, d4_proc_ack;
   logic [127:0] d4_row_a, d4_col_b;
   logic         p4_ready = 1'b0;
   logic [127:0] p4_cell = '0;

   matrix_product_sequencer #(.size(4), .cell_width(32), .width(128), .timeout_cycles(1024)) dut4 (
      .in_clk(clk), .in_reset(rst), .in_ready(d4_in_ready), .in_mat_a(d4_mat_a),
      .in_mat_b(d4_mat_b), .in_ack(d4_ack), .out_mat_c(d4_mat_c), .out_ready(d4_out_ready),
      .out_error(d4_out_error), .out_row_a(d4_row_a), .out_col_b(d4_col_b),
      .out_proc_ready(d4_proc_ready), .in_proc_cell(p4_cell), .in_proc_ready(p4_ready),
      .out_proc_ack(d4_proc_ack));

   mstate_t      m4_st = m_idle;
   int           txn4 = 0, m4_cnt = 0;
   logic [511:0] a_exp4 = '0, b_exp4 = '0;

   always @(posedge clk) begin
      if (rst) begin
         m4_st <= m_idle; p4_ready <= 1'b0; p4_cell <= '0; txn4 <= 0;
      end else begin
         case (m4_st)
            m_idle:   if (d4_proc_ready) begin txn4 <= txn4 + 1; m4_st <= m_sample; end
            m_sample: begin m4_cnt <= 2; m4_st <= m_busy; end
            m_busy: begin
               if (m4_cnt <= 1) begin
                  p4_ready <= 1'b1;
                  p4_cell  <= {96'h0, b_exp4[((txn4 - 1) % 16)*32 +: 32]};
                  m4_st    <= m_out;
               end else m4_cnt <= m4_cnt - 1;
            end
            m_out: if (d4_proc_ack) begin p4_ready <= 1'b0; m4_st <= m_idle; end
            default: m4_st <= m_idle;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst && m4_st == m_sample) begin
         check("row4_operand", d4_row_a, row_of(a_exp4, 4, ((txn4 - 1) % 16) / 4));
         check("col4_operand", d4_col_b, col_of(b_exp4, 4, ((txn4 - 1) % 16) % 4));
      end
   end

   // ---------------- helpers ----------------
   task automatic start2(input logic [127:0] a, input logic [127:0] b);
      @(negedge clk);
      d2_mat_a = a; d2_mat_b = b;
      a_exp2 = {384'h0, a}; b_exp2 = {384'h0, b};
      d2_in_ready = 1'b1;
      @(negedge clk);
      d2_in_ready = 1'b0;
   endtask

   task automatic wait_done2();
      bit ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (d2_out_ready) begin ok = 1'b1; break; end
      end
      check("done2_reached", ok, 1);
   endtask

   task automatic wait_done4();
      bit ok = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (d4_out_ready) begin ok = 1'b1; break; end
      end
      check("done4_reached", ok, 1);
   endtask

   task automatic ack2();
      d2_ack = 1'b1;
      @(negedge clk);
      d2_ack = 1'b0;
      check("ready2_cleared_after_ack", d2_out_ready, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   localparam logic [127:0] mat_a  = 128'h40800000_40400000_40000000_3F800000;
   localparam logic [127:0] mat_b  = 128'h41000000_40E00000_40C00000_40A00000;
   localparam logic [127:0] c_ab   = 128'h42480000_422C0000_41B00000_41980000;
   localparam logic [127:0] c_ba   = 128'h42380000_41F80000_42080000_41B80000;
   localparam logic [127:0] c_tmo  = 128'h42480000_422C0000_00000000_41980000;

   initial begin
      logic [511:0] ident, mb1, mb2;
      int base;
      bit hit;
      ident = '0; mb1 = '0; mb2 = '0;
      for (int k = 0; k < 4; k++) ident[(k*4 + k)*32 +: 32] = 32'h3F800000;
      for (int k = 0; k < 16; k++) begin
         mb1[k*32 +: 32] = 32'h40000000 | (k << 20) | k;
         mb2[k*32 +: 32] = 32'hC1230000 + k * 32'h111;
      end
      res2[0] = 32'h41980000; res2[1] = 32'h41B00000;
      res2[2] = 32'h422C0000; res2[3] = 32'h42480000;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_mat_c", d2_mat_c, 0);
      check("rst_flags", {d2_out_ready, d2_out_error, d2_proc_ready, d2_proc_ack}, 0);
      check("rst_operands", {d2_row_a, d2_col_b}, 0);
      check("rst4_all", {d4_mat_c, d4_out_ready, d4_out_error, d4_proc_ready, d4_proc_ack}, 0);
      rst = 1'b0;

      // Basic 2x2 product, 5-cycle latency
      base = txn2;
      start2(mat_a, mat_b);
      check("first_issue_ready", d2_proc_ready, 1);
      check("first_row_a", d2_row_a, 64'h400000003F800000);
      check("first_col_b", d2_col_b, 64'h40E0000040A00000);
      wait_done2();
      check("basic_c", d2_mat_c, c_ab);
      check("basic_error", d2_out_error, 0);
      check("basic_txn", txn2 - base, 4);
      ack2();
      check("c_retained_idle", d2_mat_c, c_ab);

      // Processor holds its ready 3 cycles past the acknowledge
      hold2 = 3; base = txn2;
      start2(mat_a, mat_b);
      wait_done2();
      check("hs_c", d2_mat_c, c_ab);
      check("hs_txn", txn2 - base, 4);
      ack2();
      hold2 = 0;

      // Cell (0,1) never answered: timeout skips it
      skip2 = 1; base = txn2;
      start2(mat_a, mat_b);
      wait_done2();
      check("tmo_error", d2_out_error, 1);
      check("tmo_c", d2_mat_c, c_tmo);
      check("tmo_txn", txn2 - base, 4);
      ack2();
      check("tmo_error_held_idle", d2_out_error, 1);
      skip2 = -1;

      // Upper-bit garbage, swapped operands, input changes after start ignored
      garbage2 = 1'b1;
      res2[0] = 32'h41B80000; res2[1] = 32'h42080000;
      res2[2] = 32'h41F80000; res2[3] = 32'h42380000;
      start2(mat_b, mat_a);
      d2_mat_a = '1; d2_mat_b = '1;
      wait_done2();
      check("mask_c", d2_mat_c, c_ba);
      check("mask_error_cleared", d2_out_error, 0);
      ack2();
      garbage2 = 1'b0;

      // Reset during WAIT of cell (1,0), then restart
      res2[0] = 32'h41980000; res2[1] = 32'h41B00000;
      res2[2] = 32'h422C0000; res2[3] = 32'h42480000;
      start2(mat_a, mat_b);
      hit = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (((txn2 - 1) % 4) == 2 && m2_st == m_busy) begin hit = 1'b1; break; end
      end
      check("reached_wait_cell10", hit, 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_mat_c", d2_mat_c, 0);
      check("midrst_flags", {d2_out_ready, d2_out_error, d2_proc_ready, d2_proc_ack}, 0);
      check("midrst_operands", {d2_row_a, d2_col_b}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_stays_idle", {d2_proc_ready, d2_out_ready}, 0);
      start2(mat_a, mat_b);
      wait_done2();
      check("restart_c", d2_mat_c, c_ab);
      check("restart_txn", txn2, 4);
      ack2();

      // Back-to-back 4x4 with in_ready held through DONE and ack
      @(negedge clk);
      d4_mat_a = ident; d4_mat_b = mb1; a_exp4 = ident; b_exp4 = mb1;
      d4_in_ready = 1'b1;
      @(negedge clk);
      check("b2b_first_issue", d4_proc_ready, 1);
      d4_mat_b = mb2;
      wait_done4();
      check("b2b_c1", d4_mat_c, mb1);
      check("b2b_txn1", txn4, 16);
      check("b2b_err1", d4_out_error, 0);
      d4_ack = 1'b1;
      @(negedge clk);
      check("b2b_idle_between", {d4_out_ready, d4_proc_ready}, 0);
      b_exp4 = mb2;
      d4_ack = 1'b0;
      @(negedge clk);
      check("b2b_second_issue", d4_proc_ready, 1);
      d4_in_ready = 1'b0;
      wait_done4();
      check("b2b_c2", d4_mat_c, mb2);
      check("b2b_txn2", txn4, 32);
      d4_ack = 1'b1;
      @(negedge clk);
      d4_ack = 1'b0;
      check("b2b_ready_cleared", d4_out_ready, 0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
